// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: operand-fetch state encoding,
// default datapath widths and the hardwired zero-register index.
package cpu_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;

  // Register index that always reads as zero and is never tracked as busy
  localparam int ZERO_REG = 0;

  // EMPTY: nothing held; STALL: instruction held waiting on a hazard;
  // VALID: operands held in the output register
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_STALL = 2'b01,
    ST_VALID = 2'b10
  } of_state_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard for in-flight destination registers.
// A set and a clear to the same index in one cycle leaves the bit set.
// The query ports report the bit as it will look after this cycle's clear,
// so a register being written back right now no longer blocks issue.
module reg_scoreboard
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  set_en,
  input  logic [ADDR_WIDTH-1:0] set_idx,
  input  logic                  clr_en,
  input  logic [ADDR_WIDTH-1:0] clr_idx,
  input  logic [ADDR_WIDTH-1:0] q_idx1,
  input  logic [ADDR_WIDTH-1:0] q_idx2,
  input  logic [ADDR_WIDTH-1:0] q_idx3,
  output logic                  q_busy1,
  output logic                  q_busy2,
  output logic                  q_busy3
);

  localparam int NREGS = 1 << ADDR_WIDTH;

  logic [NREGS-1:0] busy_r;
  logic [NREGS-1:0] busy_next_s;

  // Busy bit seen through this cycle's writeback clear
  function automatic logic busy_after_clear(
    input logic [NREGS-1:0]      busy,
    input logic [ADDR_WIDTH-1:0] idx,
    input logic                  clr,
    input logic [ADDR_WIDTH-1:0] cidx
  );
    return busy[idx] && !(clr && (cidx == idx));
  endfunction

  // Next busy vector: clear first, then set so that set wins on collision
  always_comb begin
    busy_next_s = busy_r;
    if (clr_en) begin
      busy_next_s[clr_idx] = 1'b0;
    end else begin
      busy_next_s = busy_next_s;
    end
    if (set_en) begin
      busy_next_s[set_idx] = 1'b1;
    end else begin
      busy_next_s = busy_next_s;
    end
    busy_next_s[ZERO_REG] = 1'b0;
  end

  // Busy vector register
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r <= {NREGS{1'b0}};
    end else begin
      busy_r <= busy_next_s;
    end
  end

  assign q_busy1 = busy_after_clear(busy_r, q_idx1, clr_en, clr_idx);
  assign q_busy2 = busy_after_clear(busy_r, q_idx2, clr_en, clr_idx);
  assign q_busy3 = busy_after_clear(busy_r, q_idx3, clr_en, clr_idx);

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: accepts decoded instructions, reads the register
// file, stalls on RAW/WAW hazards tracked by a busy-bit scoreboard,
// bypasses same-cycle writeback data and forwards writebacks to the
// register-file write port. Operands leave through a one-entry register.
module operand_fetch
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rs,
  input  logic [ADDR_WIDTH-1:0] in_rt,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_wen,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_a,
  output logic [DATA_WIDTH-1:0] out_b,
  output logic [ADDR_WIDTH-1:0] out_rd,
  output logic                  out_wen,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic [ADDR_WIDTH-1:0] rf_raddr1,
  output logic [ADDR_WIDTH-1:0] rf_raddr2,
  input  logic [DATA_WIDTH-1:0] rf_rdata1,
  input  logic [DATA_WIDTH-1:0] rf_rdata2,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata
);

  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

  of_state_e             state_r;
  logic [ADDR_WIDTH-1:0] rs_r;
  logic [ADDR_WIDTH-1:0] rt_r;
  logic [ADDR_WIDTH-1:0] rd_r;
  logic                  wen_r;

  logic [ADDR_WIDTH-1:0] cur_rs_s;
  logic [ADDR_WIDTH-1:0] cur_rt_s;
  logic [ADDR_WIDTH-1:0] cur_rd_s;
  logic                  cur_wen_s;
  logic                  accept_s;
  logic                  hazard_s;
  logic                  capture_s;
  logic                  set_en_s;
  logic                  busy_rs_s;
  logic                  busy_rt_s;
  logic                  busy_rd_s;
  logic [DATA_WIDTH-1:0] opnd_a_s;
  logic [DATA_WIDTH-1:0] opnd_b_s;

  // Register 0 reads as zero; otherwise a same-cycle writeback beats the file
  function automatic logic [DATA_WIDTH-1:0] select_operand(
    input logic [ADDR_WIDTH-1:0] src,
    input logic [DATA_WIDTH-1:0] rdata,
    input logic                  wbv,
    input logic [ADDR_WIDTH-1:0] wba,
    input logic [DATA_WIDTH-1:0] wbd
  );
    if (src == ZERO_IDX) begin
      return {DATA_WIDTH{1'b0}};
    end else if (wbv && (wba == src)) begin
      return wbd;
    end else begin
      return rdata;
    end
  endfunction

  // Upstream handshake: free when empty, or when the held result drains now
  always_comb begin
    in_ready = 1'b0;
    if (reset) begin
      in_ready = 1'b0;
    end else begin
      case (state_r)
        ST_EMPTY: in_ready = 1'b1;
        ST_VALID: in_ready = out_ready;
        default:  in_ready = 1'b0;
      endcase
    end
  end

  // Instruction under evaluation: the held one while stalled, else the input
  always_comb begin
    cur_rs_s  = in_rs;
    cur_rt_s  = in_rt;
    cur_rd_s  = in_rd;
    cur_wen_s = in_wen;
    if (state_r == ST_STALL) begin
      cur_rs_s  = rs_r;
      cur_rt_s  = rt_r;
      cur_rd_s  = rd_r;
      cur_wen_s = wen_r;
    end else begin
      cur_rs_s  = in_rs;
      cur_rt_s  = in_rt;
      cur_rd_s  = in_rd;
      cur_wen_s = in_wen;
    end
  end

  assign rf_raddr1 = cur_rs_s;
  assign rf_raddr2 = cur_rt_s;
  assign accept_s  = in_valid && in_ready;

  assign hazard_s = ((cur_rs_s != ZERO_IDX) && busy_rs_s) ||
                    ((cur_rt_s != ZERO_IDX) && busy_rt_s) ||
                    (cur_wen_s && (cur_rd_s != ZERO_IDX) && busy_rd_s);

  assign opnd_a_s = select_operand(cur_rs_s, rf_rdata1, wb_valid, wb_addr, wb_data);
  assign opnd_b_s = select_operand(cur_rt_s, rf_rdata2, wb_valid, wb_addr, wb_data);

  // Operands are captured whenever the current instruction moves into VALID
  always_comb begin
    capture_s = 1'b0;
    if (reset) begin
      capture_s = 1'b0;
    end else if (accept_s) begin
      capture_s = !hazard_s;
    end else if (state_r == ST_STALL) begin
      capture_s = !hazard_s;
    end else begin
      capture_s = 1'b0;
    end
  end

  assign set_en_s = capture_s && cur_wen_s && (cur_rd_s != ZERO_IDX);

  reg_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_scoreboard (
    .clk     (clk),
    .reset   (reset),
    .set_en  (set_en_s),
    .set_idx (cur_rd_s),
    .clr_en  (wb_valid),
    .clr_idx (wb_addr),
    .q_idx1  (cur_rs_s),
    .q_idx2  (cur_rt_s),
    .q_idx3  (cur_rd_s),
    .q_busy1 (busy_rs_s),
    .q_busy2 (busy_rt_s),
    .q_busy3 (busy_rd_s)
  );

  // Writeback forwarding to the register-file write port
  assign rf_wen   = wb_valid && (wb_addr != ZERO_IDX);
  assign rf_waddr = wb_addr;
  assign rf_wdata = wb_data;

  // Stage FSM with held instruction and registered operand outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_EMPTY;
      rs_r      <= {ADDR_WIDTH{1'b0}};
      rt_r      <= {ADDR_WIDTH{1'b0}};
      rd_r      <= {ADDR_WIDTH{1'b0}};
      wen_r     <= 1'b0;
      out_valid <= 1'b0;
      out_a     <= {DATA_WIDTH{1'b0}};
      out_b     <= {DATA_WIDTH{1'b0}};
      out_rd    <= {ADDR_WIDTH{1'b0}};
      out_wen   <= 1'b0;
    end else begin
      if (accept_s) begin
        rs_r  <= in_rs;
        rt_r  <= in_rt;
        rd_r  <= in_rd;
        wen_r <= in_wen;
      end
      if (capture_s) begin
        out_a   <= opnd_a_s;
        out_b   <= opnd_b_s;
        out_rd  <= cur_rd_s;
        out_wen <= cur_wen_s;
      end
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            state_r   <= hazard_s ? ST_STALL : ST_VALID;
            out_valid <= !hazard_s;
          end
        end
        ST_STALL: begin
          if (!hazard_s) begin
            state_r   <= ST_VALID;
            out_valid <= 1'b1;
          end
        end
        ST_VALID: begin
          if (out_ready) begin
            if (accept_s) begin
              state_r   <= hazard_s ? ST_STALL : ST_VALID;
              out_valid <= !hazard_s;
            end else begin
              state_r   <= ST_EMPTY;
              out_valid <= 1'b0;
            end
          end
        end
        default: begin
          state_r   <= ST_EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios followed by a
// randomized phase, all compared against a transaction-level model of the
// stage (held instruction, pending-register set, register contents).
module tb_operand_fetch;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_rs, in_rt, in_rd;
  logic          in_wen;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_a, out_b;
  logic [AW-1:0] out_rd;
  logic          out_wen;
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic [AW-1:0] rf_raddr1, rf_raddr2;
  logic [DW-1:0] rf_rdata1, rf_rdata2;
  logic          rf_wen;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;

  int n_tests;
  int n_fail;

  operand_fetch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_wen(in_wen),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_rd(out_rd), .out_wen(out_wen),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  // Register-file contents after reset; entry 0 holds junk the stage must ignore
  function automatic logic [DW-1:0] init_val(input int i);
    if (i == 0) return 32'hDEAD_BEEF;
    return 32'hA500_0000 | 32'(i);
  endfunction

  // Environment register file driven by the stage's ports
  logic [DW-1:0] rf_mem [NR];
  assign rf_rdata1 = rf_mem[rf_raddr1];
  assign rf_rdata2 = rf_mem[rf_raddr2];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NR; i++) rf_mem[i] <= init_val(i);
    end else if (rf_wen) begin
      rf_mem[rf_waddr] <= rf_wdata;
    end
  end

  // ---------------- reference model ----------------
  bit            m_held;   // an instruction occupies the stage
  bit            m_rdy;    // its operands are being presented
  logic [AW-1:0] m_rs, m_rt, m_rd;
  bit            m_wen;
  logic [DW-1:0] m_a, m_b;
  logic [AW-1:0] m_ord;
  bit            m_owen;
  bit [NR-1:0]   m_busy;
  logic [DW-1:0] ref_regs [NR];

  function automatic bit busy_now(input logic [AW-1:0] idx);
    return (idx != 5'd0) && m_busy[idx] && !(wb_valid && wb_addr == idx);
  endfunction

  function automatic bit haz(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                             input logic [AW-1:0] rd, input bit wen);
    return busy_now(rs) || busy_now(rt) || (wen && busy_now(rd));
  endfunction

  function automatic logic [DW-1:0] opval(input logic [AW-1:0] src);
    if (src == 5'd0) return 32'd0;
    if (wb_valid && wb_addr == src) return wb_data;
    return ref_regs[src];
  endfunction

  function automatic bit exp_in_ready();
    return !reset && (!m_held || (m_rdy && out_ready));
  endfunction

  // Advance the model by one clock using the inputs currently applied
  task automatic model_step();
    bit            take;
    bit            do_set;
    logic [AW-1:0] set_idx;
    if (reset) begin
      m_held = 1'b0; m_rdy = 1'b0;
      m_a = 32'd0; m_b = 32'd0; m_ord = 5'd0; m_owen = 1'b0;
      m_busy = '0;
      for (int i = 0; i < NR; i++) ref_regs[i] = init_val(i);
      return;
    end
    take    = in_valid && exp_in_ready();
    do_set  = 1'b0;
    set_idx = 5'd0;
    if (take) begin
      m_held = 1'b1;
      m_rs = in_rs; m_rt = in_rt; m_rd = in_rd; m_wen = in_wen;
      m_rdy = !haz(in_rs, in_rt, in_rd, in_wen);
      if (m_rdy) begin
        m_a = opval(in_rs); m_b = opval(in_rt); m_ord = in_rd; m_owen = in_wen;
        do_set = in_wen && (in_rd != 5'd0); set_idx = in_rd;
      end
    end else if (m_held && !m_rdy) begin
      if (!haz(m_rs, m_rt, m_rd, m_wen)) begin
        m_rdy = 1'b1;
        m_a = opval(m_rs); m_b = opval(m_rt); m_ord = m_rd; m_owen = m_wen;
        do_set = m_wen && (m_rd != 5'd0); set_idx = m_rd;
      end
    end else if (m_held && m_rdy && out_ready) begin
      m_held = 1'b0; m_rdy = 1'b0;
    end
    if (wb_valid) m_busy[wb_addr] = 1'b0;
    if (do_set) m_busy[set_idx] = 1'b1;
    if (wb_valid && wb_addr != 5'd0) ref_regs[wb_addr] = wb_data;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: check combinational outputs, step model, check registered outputs
  task automatic cycle();
    bit was_rst;
    #1;
    chk("in_ready", 32'(in_ready), 32'(exp_in_ready()));
    chk("rf_raddr1", 32'(rf_raddr1), 32'((m_held && !m_rdy) ? m_rs : in_rs));
    chk("rf_raddr2", 32'(rf_raddr2), 32'((m_held && !m_rdy) ? m_rt : in_rt));
    chk("rf_wen", 32'(rf_wen), 32'(wb_valid && (wb_addr != 5'd0)));
    chk("rf_waddr", 32'(rf_waddr), 32'(wb_addr));
    chk("rf_wdata", rf_wdata, wb_data);
    was_rst = reset;
    model_step();
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_rdy));
    if (m_rdy || was_rst) begin
      chk("out_a", out_a, m_a);
      chk("out_b", out_b, m_b);
      chk("out_rd", 32'(out_rd), 32'(m_ord));
      chk("out_wen", 32'(out_wen), 32'(m_owen));
    end
  endtask

  task automatic issue(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                       input logic [AW-1:0] rd, input logic wen);
    in_valid = 1'b1; in_rs = rs; in_rt = rt; in_rd = rd; in_wen = wen;
  endtask

  logic [DW-1:0] snap_a;

  initial begin
    n_tests = 0; n_fail = 0;
    reset = 1'b1; in_valid = 1'b0; in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0;
    in_wen = 1'b0; out_ready = 1'b1; wb_valid = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    m_held = 1'b0; m_rdy = 1'b0; m_busy = '0;
    m_rs = 5'd0; m_rt = 5'd0; m_rd = 5'd0; m_wen = 1'b0;
    m_a = 32'd0; m_b = 32'd0; m_ord = 5'd0; m_owen = 1'b0;
    for (int i = 0; i < NR; i++) ref_regs[i] = init_val(i);

    // Reset
    cycle(); cycle();
    reset = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_a", out_a, 32'd0);
    chk("rst_out_rd", 32'(out_rd), 32'd0);

    // Preload r1=5, r2=7 through the writeback port
    wb_valid = 1'b1; wb_addr = 5'd1; wb_data = 32'd5; cycle();
    wb_addr = 5'd2; wb_data = 32'd7; cycle();
    wb_valid = 1'b0;

    // Back-to-back issue
    issue(5'd1, 5'd2, 5'd3, 1'b1); cycle();
    chk("b2b_valid", 32'(out_valid), 32'd1);
    chk("b2b_a", out_a, 32'd5);
    chk("b2b_b", out_b, 32'd7);
    chk("b2b_rd", 32'(out_rd), 32'd3);

    // RAW stall on r3, resolved by a bypassed writeback
    issue(5'd3, 5'd0, 5'd5, 1'b1); cycle();
    chk("raw_stall_valid", 32'(out_valid), 32'd0);
    #1 chk("raw_stall_ready", 32'(in_ready), 32'd0);
    cycle();
    in_valid = 1'b0; wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h1234; cycle();
    wb_valid = 1'b0;
    chk("raw_bypass_valid", 32'(out_valid), 32'd1);
    chk("raw_bypass_a", out_a, 32'h1234);

    // Register 0
    issue(5'd0, 5'd0, 5'd0, 1'b1);
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_0000;
    #1 chk("r0_rf_wen", 32'(rf_wen), 32'd0);
    cycle();
    wb_valid = 1'b0;
    chk("r0_a", out_a, 32'd0);
    chk("r0_b", out_b, 32'd0);

    // Set wins over a same-cycle clear of r4
    issue(5'd0, 5'd0, 5'd4, 1'b1); cycle();
    issue(5'd0, 5'd0, 5'd4, 1'b1); wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 32'h44; cycle();
    wb_valid = 1'b0;
    chk("setwins_waw_valid", 32'(out_valid), 32'd1);
    issue(5'd4, 5'd0, 5'd0, 1'b0); cycle();
    chk("setwins_stall", 32'(out_valid), 32'd0);
    in_valid = 1'b0; wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 32'h4444; cycle();
    wb_valid = 1'b0;
    chk("setwins_release_a", out_a, 32'h4444);

    // Backpressure: outputs hold, then accept-and-replace
    issue(5'd1, 5'd2, 5'd6, 1'b0); cycle();
    snap_a = out_a;
    out_ready = 1'b0; issue(5'd2, 5'd1, 5'd7, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_in_ready", 32'(in_ready), 32'd0);
      cycle();
      chk("bp_hold_a", out_a, snap_a);
      chk("bp_hold_rd", 32'(out_rd), 32'd6);
    end
    out_ready = 1'b1; cycle();
    chk("bp_replace_rd", 32'(out_rd), 32'd7);
    chk("bp_replace_a", out_a, 32'd7);
    chk("bp_replace_b", out_b, 32'd5);

    // Reset while stalled
    issue(5'd0, 5'd0, 5'd3, 1'b1); cycle();
    issue(5'd3, 5'd0, 5'd0, 1'b0); cycle();
    chk("rst_mid_stall", 32'(out_valid), 32'd0);
    in_valid = 1'b0; reset = 1'b1; cycle();
    reset = 1'b0;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    issue(5'd3, 5'd0, 5'd0, 1'b0); cycle();
    chk("rst_mid_noStall", 32'(out_valid), 32'd1);
    chk("rst_mid_a", out_a, init_val(3));

    // Randomized traffic on a small register window to provoke hazards
    for (int n = 0; n < 500; n++) begin
      reset     = ($urandom_range(0, 63) == 0);
      in_valid  = 1'($urandom_range(0, 1));
      in_rs     = 5'($urandom_range(0, 7));
      in_rt     = 5'($urandom_range(0, 7));
      in_rd     = 5'($urandom_range(0, 7));
      in_wen    = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      wb_valid  = 1'($urandom_range(0, 1));
      wb_addr   = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand-fetch stage of the multi-cycle CPU datapath, acting as the initiator on both ports of `reg_file`. It accepts decoded instructions over a valid/ready handshake, drives the read addresses, and tracks in-flight destination registers in a busy-bit scoreboard. It stalls on RAW/WAW hazards, bypasses same-cycle writeback data, and forwards writeback requests to the register-file write port. Operands are presented to the execute stage through a one-entry output register.

## Interface
- `DATA_WIDTH`, default 32, operand/register width
- `ADDR_WIDTH`, default 5, register index width (2^ADDR_WIDTH registers; register 0 hardwired to zero)

- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  reset, synchronous active-high
- `in_valid`  in  1  decoded instruction available
- `in_ready`  out  1  stage accepts instruction this cycle
- `in_rs`, `in_rt`  in  ADDR_WIDTH  source register indices
- `in_rd`  in  ADDR_WIDTH  destination index
- `in_wen`  in  1  instruction writes `in_rd`
- `out_valid`  out  1  operands valid for execute
- `out_ready`  in  1  execute accepts
- `out_a`, `out_b`  out  DATA_WIDTH  values of rs, rt
- `out_rd`  out  ADDR_WIDTH  destination index
- `out_wen`  out  1  destination write flag
- `wb_valid`  in  1  writeback request (always accepted)
- `wb_addr`  in  ADDR_WIDTH  writeback register
- `wb_data`  in  DATA_WIDTH  writeback value
- `rf_raddr1`, `rf_raddr2`  out  ADDR_WIDTH  register-file read addresses
- `rf_rdata1`, `rf_rdata2`  in  DATA_WIDTH  combinational read data
- `rf_wen`  out  1  register-file write enable
- `rf_waddr`  out  ADDR_WIDTH  register-file write address
- `rf_wdata`  out  DATA_WIDTH  register-file write data

## Operation
- **States:** EMPTY (nothing held), STALL (instruction held, hazard pending), VALID (operands held in output register).
- **`in_ready`:** `!reset && (state==EMPTY || (state==VALID && out_ready))`.
- **Accept:** an accept is `in_valid && in_ready`. On accept, latch rs/rt/rd/wen. `rf_raddr1/2` = `in_rs/in_rt` in EMPTY and VALID, and the held rs/rt in STALL.
- **Hazard:** `(rs!=0 && busy[rs]) || (rt!=0 && busy[rt]) || (wen && rd!=0 && busy[rd])`.
  - A busy bit whose register is written back this cycle (`wb_valid && wb_addr==idx`) counts as clear.
- **Bypass:** operand = `wb_data` when `wb_valid && wb_addr==src && src!=0`. Otherwise operand = 0 when src==0, else `rf_rdata`.
- **Transitions:**
  - Accept with no hazard: capture operands, go to VALID.
  - Accept with hazard: go to STALL.
  - STALL: re-evaluate the hazard every cycle. When clear, capture operands (with bypass) and go to VALID.
  - VALID with `out_ready` and no accept: go to EMPTY.
  - VALID with `out_ready` and accept: follow the accept rules above.
- **Scoreboard set:** `busy[rd]` is set when an instruction with `wen && rd!=0` enters VALID.
- **Scoreboard clear:** `busy[wb_addr]` is cleared on `wb_valid`. If set and clear hit the same index in one cycle, set wins. `busy[0]` is constant 0.
- **Write port:** `rf_wen = wb_valid && wb_addr!=0`; `rf_waddr = wb_addr`; `rf_wdata = wb_data` (combinational).
- **Reset:** state EMPTY, all busy bits 0.
  - Output values: `out_valid=0`, `out_a=0`, `out_b=0`, `out_rd=0`, `out_wen=0`, `in_ready=0`.
  - A held instruction is discarded on reset, including in STALL.
- **Output stability:** `out_*` are stable while `out_valid && !out_ready`.

## Timing
- **No-hazard latency:** accept at cycle t gives `out_valid` in t+1.
- **Stall latency:** a clearing writeback at cycle t gives `out_valid` in t+1, with `wb_data` bypassed.
- **Throughput:** one instruction per cycle with `out_ready` held high and no hazards.
- **Write-port latency:** the `wb` to `rf_w*` path has zero cycles of latency.

## Structure
- **Shared package `cpu_pkg`:** state encoding (EMPTY/STALL/VALID), `DATA_WIDTH`/`ADDR_WIDTH` defaults, and the zero-register constant.
- **Sub-module `reg_scoreboard`:** busy vector with set/clear ports, set-priority, and three combinational query ports returning "busy after this cycle's clear".

## Test plan
- **Back-to-back issue:** r1=5, r2=7 preloaded. Issue rs=1, rt=2, rd=3, wen=1 -> next cycle `out_a=5`, `out_b=7`, `out_rd=3`, and busy[3] is set.
- **RAW stall:** issue rd=3, then an instruction with rs=3. The second holds in STALL with `out_valid=0` and `in_ready=0`. `wb_valid`, `wb_addr=3`, `wb_data=0x1234` -> next cycle `out_a=0x1234`.
- **Register 0:** rs=0, rt=0, rd=0, wen=1 -> operands 0, no busy bit set. `wb_addr=0` -> `rf_wen=0`.
- **Set-wins:** writeback to r4 in the same cycle as a new rd=4 issue -> busy[4] remains 1. A following rs=4 instruction stalls.
- **Backpressure:** `out_ready=0` for 3 cycles -> `out_*` are unchanged and `in_ready=0`. Then `out_ready=1` with `in_valid=1` -> accept and replace in the same cycle.
- **Reset mid-operation:** reset asserted in STALL -> next cycle `out_valid=0`, busy all 0. After release, an issue with rs=3 proceeds without stall.
